scan_code_decoder: RTL and testbench
====================================

// Module: scan_code_decoder
// PURPOSE
//  Stateful PS/2 set-2 decoder that turns the raw byte stream into key tokens.
//  Tracks E0/F0 prefixes, break codes and shift state, and resolves shift+5 to '%'.
//  Buffers tokens in a FIFO with a valid/ready output. Sits between the PS/2 byte receiver and the calculator core.
// PARAMETERS
//  FIFO_DEPTH      4  token FIFO entries; power of two, >=2
//  KEY_W           4  token width, >=4; tokens are zero-extended
//  SUPPRESS_REPEAT 0  1: drop typematic repeats (same make code again with no break in between)
// PORTS
//  clk             in   1       system clock
//  rst_n           in   1       synchronous active-low reset
//  scan_code_in    in   8       byte from the PS/2 receiver
//  scan_code_valid in   1       one-cycle strobe; scan_code_in is valid in that cycle
//  key_out         out  KEY_W   FIFO head token
//  key_valid       out  1       FIFO not empty
//  key_ready       in   1       consumer accepts; pop when key_valid && key_ready
//  shift_active    out  1       left (12) or right (59) shift is currently held
//  overflow        out  1       one-cycle pulse: a token was dropped because the FIFO was full
//  fifo_level      out  $clog2(FIFO_DEPTH+1)  occupancy
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - FSM -> IDLE; FIFO emptied; shift flags and last-make register cleared.
//   - All outputs 0. This applies mid-sequence too: a pending E0/F0 prefix is discarded.
//  FSM advances only on scan_code_valid. States and transitions:
//   - IDLE: E0->EXT; F0->BRK; otherwise the byte is a make code.
//   - EXT: F0->EXT_BRK; otherwise an extended make -> IDLE.
//   - BRK: any byte is a break code -> IDLE. EXT_BRK: any byte is an extended break -> IDLE.
//  Make code (IDLE), token mapping:
//   - digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
//   - 4E -> '-'(10); 55 with shift -> '+'(11); 3E with shift -> '*'(12);
//     2E with shift -> '%'(13); 5A -> ENTER(14).
//   - 12/59 set their shift flag; no token.
//   - Any other code -> ERROR(15), pushed.
//  Break codes clear the matching shift flag and the last-make register; never push a token.
//  Extended make/break without KEYPAD_EN: no token, no error.
//  SUPPRESS_REPEAT=1: a make equal to the last-make register is dropped. The last make is recorded on every make, including shift.
//  Latency: strobe at cycle N -> token at the FIFO head, key_valid=1, in cycle N+1 if the FIFO was empty.
//  FIFO behaviour:
//   - Full with no pop in the same cycle: the push is dropped and overflow pulses.
//   - Full with a pop in the same cycle: the push is accepted and the level is unchanged.
//   - Empty with a push in the same cycle: no bypass; the token appears next cycle.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - key_out holds its value while key_valid && !key_ready.
// CONFIGURATION
//  KEYPAD_EN defined: numpad codes decode as follows.
//   - Digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
//   - Operators: 7B='-', 79='+', 7C='*'; E0 5A -> ENTER.
//  KEYPAD_EN undefined: non-extended numpad codes -> ERROR; E0 5A is ignored.
// STRUCTURE
//  Package kbd_pkg:
//   - key_token_e (DIGIT0..9, MINUS, PLUS, MUL, PCT, ENTER, ERROR)
//   - decode_state_e (IDLE, EXT, BRK, EXT_BRK)
//   - scan-code localparams (SC_EXT=E0, SC_BREAK=F0, SC_LSHIFT=12, SC_RSHIFT=59)
//  Sub-module key_token_fifo (FIFO_DEPTH, KEY_W): sync FIFO providing full/empty/level/overflow.
//  The top level holds the FSM, shift/last-make registers and the decode function.
// TESTING
//  1. Bytes 16, F0 16 with key_ready=1 -> exactly one token 1; key_valid high for one cycle only.
//  2. 12, 2E, F0 2E, F0 12, 2E -> tokens 13 then 5; shift_active=1 between 12 and F0 12.
//  3. key_ready=0, FIFO_DEPTH=4, five makes of 1E -> level 4, overflow pulses once;
//     then pop with a simultaneous push -> level stays 4.
//  4. E0 then reset mid-stream, then 5A -> one token ENTER(14); no extended handling.
//  5. SUPPRESS_REPEAT=1: 26, 26, 26, F0 26, 26 -> tokens 3, 3.
//     Byte 0x0E -> ERROR(15).
//  6. KEYPAD_EN defined: 69, E0 5A -> tokens 1, 14. KEYPAD_EN undefined: 69 -> 15; E0 5A -> nothing.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 key decoder.
package kbd_pkg;

    // Token values handed to the calculator core (zero-extended to KEY_W).
    typedef enum logic [3:0] {
        DIGIT0, DIGIT1, DIGIT2, DIGIT3, DIGIT4,
        DIGIT5, DIGIT6, DIGIT7, DIGIT8, DIGIT9,
        MINUS, PLUS, MUL, PCT, ENTER, ERROR
    } key_token_e;

    // Prefix tracking: which prefix bytes have been seen for the current key.
    typedef enum logic [1:0] {
        IDLE, EXT, BRK, EXT_BRK
    } decode_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

endpackage

// File: rtl/key_token_fifo.sv
// Synchronous token FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and overflow pulses
// in the following cycle. No bypass: a push into an empty FIFO shows next cycle.
module key_token_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_W      = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [KEY_W-1:0] push_data,
    input  logic             pop,
    output logic [KEY_W-1:0] head,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    logic [KEY_W-1:0] mem_q [FIFO_DEPTH];
    logic [KEY_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full, do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == LVL_W'(FIFO_DEPTH));
    assign level    = cnt_q;
    assign overflow = ovf_q;
    // Head reads as zero while empty so outputs are clean after reset.
    assign head     = empty ? '0 : mem_q[rd_q];

    // Next-state: pointer advance, storage write, occupancy and drop detection.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        ovf_d   = push && !do_push;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - LVL_W'(1);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/scan_code_decoder.sv
// PS/2 set-2 byte stream -> calculator key tokens, buffered in a token FIFO.
// Optional macro KEYPAD_EN: decode numpad makes and E0 5A (keypad ENTER).
module scan_code_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int KEY_W           = 4,
    parameter int SUPPRESS_REPEAT = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        scan_code_in,
    input  logic                              scan_code_valid,
    output logic [KEY_W-1:0]                  key_out,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic                              shift_active,
    output logic                              overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    // Non-extended make code to token; shift only alters 55, 3E and 2E.
    function automatic key_token_e map_make(input logic [7:0] code, input logic shift);
        map_make = ERROR;
        case (code)
            8'h45: map_make = DIGIT0;
            8'h16: map_make = DIGIT1;
            8'h1E: map_make = DIGIT2;
            8'h26: map_make = DIGIT3;
            8'h25: map_make = DIGIT4;
            8'h2E: map_make = shift ? PCT : DIGIT5;
            8'h36: map_make = DIGIT6;
            8'h3D: map_make = DIGIT7;
            8'h3E: map_make = shift ? MUL : DIGIT8;
            8'h46: map_make = DIGIT9;
            8'h4E: map_make = MINUS;
            8'h55: map_make = shift ? PLUS : ERROR;
            8'h5A: map_make = ENTER;
`ifdef KEYPAD_EN
            8'h70: map_make = DIGIT0;
            8'h69: map_make = DIGIT1;
            8'h72: map_make = DIGIT2;
            8'h7A: map_make = DIGIT3;
            8'h6B: map_make = DIGIT4;
            8'h73: map_make = DIGIT5;
            8'h74: map_make = DIGIT6;
            8'h6C: map_make = DIGIT7;
            8'h75: map_make = DIGIT8;
            8'h7D: map_make = DIGIT9;
            8'h7B: map_make = MINUS;
            8'h79: map_make = PLUS;
            8'h7C: map_make = MUL;
`endif
            default: map_make = ERROR;
        endcase
    endfunction

    decode_state_e state_q, state_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic [7:0]    last_make_q, last_make_d;
    logic          last_vld_q, last_vld_d;
    logic          push;
    key_token_e    tok;
    logic          fifo_empty;

    assign shift_active = lshift_q || rshift_q;
    assign key_valid    = !fifo_empty;

    // Prefix FSM, shift/last-make tracking and token generation.
    always_comb begin
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        last_make_d = last_make_q;
        last_vld_d  = last_vld_q;
        push        = 1'b0;
        tok         = ERROR;
        if (scan_code_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_code_in == SC_EXT) begin
                        state_d = EXT;
                    end else if (scan_code_in == SC_BREAK) begin
                        state_d = BRK;
                    end else if (!(SUPPRESS_REPEAT != 0 && last_vld_q &&
                                   last_make_q == scan_code_in)) begin
                        last_make_d = scan_code_in;
                        last_vld_d  = 1'b1;
                        if (scan_code_in == SC_LSHIFT) begin
                            lshift_d = 1'b1;
                        end else if (scan_code_in == SC_RSHIFT) begin
                            rshift_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            tok  = map_make(scan_code_in, shift_active);
                        end
                    end
                end
                EXT: begin
                    if (scan_code_in == SC_BREAK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
`ifdef KEYPAD_EN
                        if (scan_code_in == SC_ENTER) begin
                            push = 1'b1;
                            tok  = ENTER;
                        end
`endif
                    end
                end
                BRK: begin
                    state_d    = IDLE;
                    last_vld_d = 1'b0;
                    if (scan_code_in == SC_LSHIFT) lshift_d = 1'b0;
                    if (scan_code_in == SC_RSHIFT) rshift_d = 1'b0;
                end
                default: begin
                    state_d    = IDLE;
                    last_vld_d = 1'b0;
                end
            endcase
        end
    end

    // Decoder state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            last_make_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            last_make_q <= last_make_d;
            last_vld_q  <= last_vld_d;
        end
    end

    key_token_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .KEY_W      (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (KEY_W'(tok)),
        .pop       (key_ready),
        .head      (key_out),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_scan_code_decoder.sv
// Bench for scan_code_decoder: one default instance and one with repeat
// suppression, both driven by the same byte stream and checked every cycle
// against a token-queue reference model.
module tb_scan_code_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_code_in = 8'h00;
    logic       scan_code_valid = 1'b0;
    logic       key_ready = 1'b0;

    logic [3:0] ko0, ko1;
    logic       kv0, kv1, sh0, sh1, ov0, ov1;
    logic [2:0] lv0, lv1;

    always #5 clk = ~clk;

    scan_code_decoder u_dut (
        .clk(clk), .rst_n(rst_n), .scan_code_in(scan_code_in),
        .scan_code_valid(scan_code_valid), .key_out(ko0), .key_valid(kv0),
        .key_ready(key_ready), .shift_active(sh0), .overflow(ov0), .fifo_level(lv0)
    );

    scan_code_decoder #(.FIFO_DEPTH(4), .KEY_W(4), .SUPPRESS_REPEAT(1)) u_dut_sr (
        .clk(clk), .rst_n(rst_n), .scan_code_in(scan_code_in),
        .scan_code_valid(scan_code_valid), .key_out(ko1), .key_valid(kv1),
        .key_ready(key_ready), .shift_active(sh1), .overflow(ov1), .fifo_level(lv1)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: token table plus per-instance queue and key state.
    int tmap [256];
    int mq [2][8];
    int mn [2];
    bit e0 [2], f0 [2], lsh [2], rsh [2], ovf [2];
    int last [2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tok_of(input int code, input bit sh);
        if (sh && code == 'h55) return 11;
        if (sh && code == 'h3E) return 12;
        if (sh && code == 'h2E) return 13;
        return tmap[code];
    endfunction

    task automatic model_step(input int i, input bit sr, input bit rst,
                              input bit v, input int b, input bit rdy);
        bit push;
        int tok;
        push = 0;
        tok  = 0;
        ovf[i] = 0;
        if (rst) begin
            mn[i] = 0; e0[i] = 0; f0[i] = 0; lsh[i] = 0; rsh[i] = 0; last[i] = -1;
            return;
        end
        if (v) begin
            if (!e0[i] && !f0[i]) begin
                if (b == 'hE0) e0[i] = 1;
                else if (b == 'hF0) f0[i] = 1;
                else if (!(sr && last[i] == b)) begin
                    last[i] = b;
                    if (b == 'h12) lsh[i] = 1;
                    else if (b == 'h59) rsh[i] = 1;
                    else begin
                        push = 1;
                        tok  = tok_of(b, lsh[i] | rsh[i]);
                    end
                end
            end else if (e0[i] && !f0[i]) begin
                if (b == 'hF0) f0[i] = 1;
                else begin
                    e0[i] = 0;
`ifdef KEYPAD_EN
                    if (b == 'h5A) begin push = 1; tok = 14; end
`endif
                end
            end else if (f0[i] && !e0[i]) begin
                f0[i] = 0;
                last[i] = -1;
                if (b == 'h12) lsh[i] = 0;
                if (b == 'h59) rsh[i] = 0;
            end else begin
                e0[i] = 0; f0[i] = 0; last[i] = -1;
            end
        end
        if (mn[i] > 0 && rdy) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mn[i]--;
        end
        if (push) begin
            if (mn[i] < 4) begin mq[i][mn[i]] = tok; mn[i]++; end
            else ovf[i] = 1;
        end
    endtask

    task automatic check_inst(input int i, input int ko, input bit kv, input bit sh,
                              input bit ov, input int lv);
        chk($sformatf("u%0d_key_valid", i), kv, mn[i] > 0);
        if (mn[i] > 0) chk($sformatf("u%0d_key_out", i), ko, mq[i][0]);
        chk($sformatf("u%0d_level", i), lv, mn[i]);
        chk($sformatf("u%0d_shift", i), sh, lsh[i] | rsh[i]);
        chk($sformatf("u%0d_overflow", i), ov, ovf[i]);
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic cyc(input bit v, input logic [7:0] b, input bit rdy, input bit rst = 0);
        scan_code_valid = v;
        scan_code_in    = b;
        key_ready       = rdy;
        rst_n           = !rst;
        @(posedge clk);
        model_step(0, 0, rst, v, int'(b), rdy);
        model_step(1, 1, rst, v, int'(b), rdy);
        @(negedge clk);
        check_inst(0, int'(ko0), kv0, sh0, ov0, int'(lv0));
        check_inst(1, int'(ko1), kv1, sh1, ov1, int'(lv1));
        scan_code_valid = 1'b0;
    endtask

    logic [7:0] pool [20] = '{8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E, 8'h55, 8'h45, 8'h46,
                              8'h4E, 8'h5A, 8'h12, 8'h59, 8'hE0, 8'hF0, 8'hF0, 8'h69,
                              8'h7C, 8'h0E, 8'h12, 8'hE0};

    initial begin
        for (int k = 0; k < 256; k++) tmap[k] = 15;
        tmap['h45] = 0; tmap['h16] = 1; tmap['h1E] = 2; tmap['h26] = 3; tmap['h25] = 4;
        tmap['h2E] = 5; tmap['h36] = 6; tmap['h3D] = 7; tmap['h3E] = 8; tmap['h46] = 9;
        tmap['h4E] = 10; tmap['h5A] = 14;
`ifdef KEYPAD_EN
        tmap['h70] = 0; tmap['h69] = 1; tmap['h72] = 2; tmap['h7A] = 3; tmap['h6B] = 4;
        tmap['h73] = 5; tmap['h74] = 6; tmap['h6C] = 7; tmap['h75] = 8; tmap['h7D] = 9;
        tmap['h7B] = 10; tmap['h79] = 11; tmap['h7C] = 12;
`endif
        @(negedge clk);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        chk("reset_level", int'(lv0), 0);
        chk("reset_valid", kv0, 0);
        chk("reset_key_out", int'(ko0), 0);

        // make then break of '1': exactly one token, valid for one cycle
        cyc(1, 8'h16, 1);
        chk("t1_token", int'(ko0), 1);
        chk("t1_valid", kv0, 1);
        cyc(1, 8'hF0, 1);
        chk("t1_popped", kv0, 0);
        cyc(1, 8'h16, 1);
        chk("t1_no_break_token", kv0, 0);

        // shift+5 -> '%', plain 5 after shift released
        cyc(1, 8'h12, 1);
        chk("t2_shift_on", sh0, 1);
        cyc(1, 8'h2E, 1);
        chk("t2_pct", int'(ko0), 13);
        cyc(1, 8'hF0, 1); cyc(1, 8'h2E, 1); cyc(1, 8'hF0, 1);
        chk("t2_shift_still", sh0, 1);
        cyc(1, 8'h12, 1);
        chk("t2_shift_off", sh0, 0);
        cyc(1, 8'h2E, 1);
        chk("t2_five", int'(ko0), 5);

        // fill, overflow, then pop with simultaneous push
        cyc(0, 8'h00, 0, 1);
        for (int k = 0; k < 5; k++) cyc(1, 8'h1E, 0);
        chk("t3_level_full", int'(lv0), 4);
        chk("t3_overflow", ov0, 1);
        chk("t3_sr_level", int'(lv1), 1);
        cyc(0, 8'h00, 0);
        chk("t3_overflow_pulse", ov0, 0);
        cyc(1, 8'h1E, 1);
        chk("t3_level_kept", int'(lv0), 4);

        // reset discards a pending E0
        cyc(0, 8'h00, 1, 1);
        cyc(1, 8'hE0, 1);
        cyc(0, 8'h00, 1, 1);
        cyc(1, 8'h5A, 1);
        chk("t4_enter", int'(ko0), 14);

        // typematic repeats and unknown code
        cyc(0, 8'h00, 1, 1);
        cyc(1, 8'h26, 1); cyc(1, 8'h26, 1); cyc(1, 8'h26, 1);
        cyc(1, 8'hF0, 1); cyc(1, 8'h26, 1); cyc(1, 8'h26, 1);
        chk("t5_sr_token", int'(ko1), 3);
        cyc(1, 8'h0E, 1);
        chk("t5_error", int'(ko1), 15);

        // numpad
        cyc(0, 8'h00, 1, 1);
        cyc(1, 8'h69, 1);
`ifdef KEYPAD_EN
        chk("t6_kp1", int'(ko0), 1);
`else
        chk("t6_kp1", int'(ko0), 15);
`endif
        cyc(1, 8'hE0, 1);
        cyc(1, 8'h5A, 1);
`ifdef KEYPAD_EN
        chk("t6_kp_enter", int'(ko0), 14);
`else
        chk("t6_kp_enter_ignored", kv0, 0);
`endif

        // randomized stream
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
            cyc($urandom_range(0, 9) < 6, b, $urandom_range(0, 1) == 1,
                $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
